decode_cycle: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes InstrD/PCD/PCPlus4D/Predict_branchD from the IF/ID register and holds the 32x32 register file, with a writeback port from W.
- Produces control, operands and immediates, and registers them into the ID/EX pipeline register under hazard-unit stall/flush control.
- Carries the fetch-stage branch prediction bit to execute, so EX can detect mispredicts.

---
 rtl/decode_cycle.sv | 187 ++++++++++++++++++
 tb/tb_decode_cycle.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file and ID/EX register.
//   clk, rst (async, active-high)
//   D side  : InstrD, PCD, PCPlus4D, Predict_branchD
//   W side  : RegWriteW, RdW, ResultW (register-file write port)
//   hazard  : StallE, FlushE in; Rs1D, Rs2D out (combinational source fields)
//   E side  : registered control, operands, immediate, register fields, PCs,
//             and the prediction bit
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            Predict_branchD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic            Predict_branchE
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic            reg_write, mem_write, jump, branch, alu_src_a, alu_src_b;
    logic [1:0]      result_src;
    logic [3:0]      alu_ctl;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1, rd2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] pc, pc4;
    logic            pred;
  } idex_t;

  logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
  idex_t dec, ex_d, ex_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic [3:0] arith_op;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign f7b5   = InstrD[30];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  // Register file; x0 is never written so it stays zero.
  always_comb begin
    rf_d = rf_q;
    if (RegWriteW && RdW != '0) rf_d[RdW] = ResultW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf_q <= '0;
    else     rf_q <= rf_d;
  end

  // Shared R/I ALU decode; only R-type turns funct3=000 into sub.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000: arith_op = (opcode == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.funct3 = funct3;
    dec.rs1    = Rs1D;
    dec.rs2    = Rs2D;
    dec.rd     = InstrD[11:7];
    dec.pc     = PCD;
    dec.pc4    = PCPlus4D;
    dec.pred   = Predict_branchD;
    // Read ports with W->D bypass so a same-cycle writeback is seen.
    dec.rd1 = (Rs1D == '0) ? '0 : (RegWriteW && RdW == Rs1D) ? ResultW : rf_q[Rs1D];
    dec.rd2 = (Rs2D == '0) ? '0 : (RegWriteW && RdW == Rs2D) ? ResultW : rf_q[Rs2D];
    case (opcode)
      OP_LW: begin
        dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.result_src = 2'b01;
        dec.imm = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        dec.mem_write = 1'b1; dec.alu_src_b = 1'b1;
        dec.imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R: begin
        dec.reg_write = 1'b1; dec.alu_ctl = arith_op;
      end
      OP_I: begin
        dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_ctl = arith_op;
        dec.imm = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_BR: begin
        dec.branch = 1'b1; dec.alu_ctl = ALU_SUB;
        dec.imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'b10;
        dec.imm = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
        dec.rs1 = '0; dec.rs2 = '0;
      end
      OP_JALR: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.result_src = 2'b10;
        dec.imm = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_ctl = ALU_PASSB;
        dec.imm = {InstrD[31:12], 12'b0};
        dec.rs1 = '0; dec.rs2 = '0;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1;
        dec.imm = {InstrD[31:12], 12'b0};
        dec.rs1 = '0; dec.rs2 = '0;
      end
      default: ; // unknown opcode or all-zero slot: bubble, no control asserted
    endcase
  end

  // ID/EX register: flush beats stall.
  always_comb begin
    if (FlushE)      ex_d = '0;
    else if (StallE) ex_d = ex_q;
    else             ex_d = dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign RegWriteE       = ex_q.reg_write;
  assign MemWriteE       = ex_q.mem_write;
  assign JumpE           = ex_q.jump;
  assign BranchE         = ex_q.branch;
  assign ALUSrcAE        = ex_q.alu_src_a;
  assign ALUSrcBE        = ex_q.alu_src_b;
  assign ResultSrcE      = ex_q.result_src;
  assign ALUControlE     = ex_q.alu_ctl;
  assign Funct3E         = ex_q.funct3;
  assign RD1E            = ex_q.rd1;
  assign RD2E            = ex_q.rd2;
  assign ImmExtE         = ex_q.imm;
  assign Rs1E            = ex_q.rs1;
  assign Rs2E            = ex_q.rs2;
  assign RdE             = ex_q.rd;
  assign PCE             = ex_q.pc;
  assign PCPlus4E        = ex_q.pc4;
  assign Predict_branchE = ex_q.pred;
endmodule

// File: tb/tb_decode_cycle.sv
// Testbench for decode_cycle: directed scenarios followed by random
// instruction/writeback/stall/flush traffic, checked against a reference
// model of the decode rules and a shadow register file.
module tb_decode_cycle;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        Predict_branchD = 1'b0, RegWriteW = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic [4:0]  RdW = '0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, Predict_branchE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Predict_branchD(Predict_branchD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Predict_branchE(Predict_branchE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rw, mw, jmp, br, asa, asb;
    logic [1:0] rsrc;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [31:0] rd1, rd2, imm;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] pc, pc4;
    logic pred;
  } e_t;

  int checks = 0, errors = 0;
  logic [31:0] ref_rf [32];
  e_t exp_q = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_e(input string s);
    chk({s, ".RegWriteE"}, 32'(RegWriteE), 32'(exp_q.rw));
    chk({s, ".MemWriteE"}, 32'(MemWriteE), 32'(exp_q.mw));
    chk({s, ".JumpE"}, 32'(JumpE), 32'(exp_q.jmp));
    chk({s, ".BranchE"}, 32'(BranchE), 32'(exp_q.br));
    chk({s, ".ALUSrcAE"}, 32'(ALUSrcAE), 32'(exp_q.asa));
    chk({s, ".ALUSrcBE"}, 32'(ALUSrcBE), 32'(exp_q.asb));
    chk({s, ".ResultSrcE"}, 32'(ResultSrcE), 32'(exp_q.rsrc));
    chk({s, ".ALUControlE"}, 32'(ALUControlE), 32'(exp_q.alu));
    chk({s, ".Funct3E"}, 32'(Funct3E), 32'(exp_q.f3));
    chk({s, ".RD1E"}, RD1E, exp_q.rd1);
    chk({s, ".RD2E"}, RD2E, exp_q.rd2);
    chk({s, ".ImmExtE"}, ImmExtE, exp_q.imm);
    chk({s, ".Rs1E"}, 32'(Rs1E), 32'(exp_q.rs1));
    chk({s, ".Rs2E"}, 32'(Rs2E), 32'(exp_q.rs2));
    chk({s, ".RdE"}, 32'(RdE), 32'(exp_q.rd));
    chk({s, ".PCE"}, PCE, exp_q.pc);
    chk({s, ".PCPlus4E"}, PCPlus4E, exp_q.pc4);
    chk({s, ".Predict_branchE"}, 32'(Predict_branchE), 32'(exp_q.pred));
  endtask

  // Register read as seen by decode, including a same-cycle writeback.
  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 0) return 0;
    if (RegWriteW && RdW == r) return ResultW;
    return ref_rf[r];
  endfunction

  // Reference decode: immediates from signed arithmetic on the word,
  // control from a per-mnemonic-class table.
  function automatic e_t ref_decode();
    e_t e = '0;
    int w = int'(InstrD);
    logic [3:0] f3map [8];
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0] op = InstrD[6:0];
    logic [2:0] f3 = InstrD[14:12];
    logic b5 = InstrD[30];
    f3map = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    imm_i = 32'(w >>> 20);
    imm_s = (32'(w >>> 25) << 5) | 32'(InstrD[11:7]);
    imm_b = (32'(w >>> 31) << 12) | (32'(InstrD[7]) << 11) | (32'(InstrD[30:25]) << 5) | (32'(InstrD[11:8]) << 1);
    imm_j = (32'(w >>> 31) << 20) | (32'(InstrD[19:12]) << 12) | (32'(InstrD[20]) << 11) | (32'(InstrD[30:21]) << 1);
    imm_u = InstrD & 32'hFFFFF000;
    e.f3 = f3; e.rs1 = InstrD[19:15]; e.rs2 = InstrD[24:20]; e.rd = InstrD[11:7];
    e.pc = PCD; e.pc4 = PCPlus4D; e.pred = Predict_branchD;
    e.rd1 = rd_reg(InstrD[19:15]); e.rd2 = rd_reg(InstrD[24:20]);
    case (op)
      7'h03: begin e.rw = 1; e.asb = 1; e.rsrc = 1; e.imm = imm_i; end
      7'h23: begin e.mw = 1; e.asb = 1; e.imm = imm_s; end
      7'h33: begin
        e.rw = 1; e.alu = f3map[f3];
        if (b5 && f3 == 0) e.alu = 4'd1;
        if (b5 && f3 == 5) e.alu = 4'd9;
      end
      7'h13: begin
        e.rw = 1; e.asb = 1; e.imm = imm_i; e.alu = f3map[f3];
        if (b5 && f3 == 5) e.alu = 4'd9;
      end
      7'h63: begin e.br = 1; e.alu = 4'd1; e.imm = imm_b; end
      7'h6F: begin e.jmp = 1; e.rw = 1; e.rsrc = 2; e.imm = imm_j; e.rs1 = 0; e.rs2 = 0; end
      7'h67: begin e.jmp = 1; e.rw = 1; e.asb = 1; e.rsrc = 2; e.imm = imm_i; end
      7'h37: begin e.rw = 1; e.asb = 1; e.alu = 4'd10; e.imm = imm_u; e.rs1 = 0; e.rs2 = 0; end
      7'h17: begin e.rw = 1; e.asa = 1; e.asb = 1; e.imm = imm_u; e.rs1 = 0; e.rs2 = 0; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: predict the ID/EX contents and the register file, then check.
  task automatic step(input string s);
    e_t nxt;
    if (FlushE) nxt = '0;
    else if (StallE) nxt = exp_q;
    else nxt = ref_decode();
    if (RegWriteW && RdW != 0) ref_rf[RdW] = ResultW;
    @(posedge clk); #1;
    exp_q = nxt;
    check_e(s);
  endtask

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f);
    logic [31:0] u = 32'(imm);
    return {u[12], u[10:5], r2, r1, f, u[4:1], u[11], 7'b1100011};
  endfunction

  logic [6:0] ops [10];

  initial begin
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    for (int i = 0; i < 32; i++) ref_rf[i] = 0;

    // Reset state
    #3; check_e("reset");
    @(negedge clk); rst = 0;

    // Write x5, then add x7,x5,x0
    RegWriteW = 1; RdW = 5; ResultW = 32'h12345678; InstrD = 0;
    step("wr_x5");
    RegWriteW = 0; InstrD = {7'd0, 5'd0, 5'd5, 3'd0, 5'd7, 7'b0110011}; PCD = 32'h100; PCPlus4D = 32'h104;
    step("add");
    chk("add.RD1E", RD1E, 32'h12345678);
    chk("add.RD2E", RD2E, 32'h0);
    chk("add.ALUControlE", 32'(ALUControlE), 32'h0);
    chk("add.RegWriteE", 32'(RegWriteE), 32'h1);

    // Bypass: write x3 while decoding addi x4,x3,-1
    RegWriteW = 1; RdW = 3; ResultW = 32'hDEADBEEF;
    InstrD = {12'hFFF, 5'd3, 3'd0, 5'd4, 7'b0010011};
    step("addi_bypass");
    chk("addi.RD1E", RD1E, 32'hDEADBEEF);
    chk("addi.ImmExtE", ImmExtE, 32'hFFFFFFFF);
    chk("addi.ALUSrcBE", 32'(ALUSrcBE), 32'h1);

    // beq x3,x5,-8 predicted taken
    RegWriteW = 0; Predict_branchD = 1; InstrD = enc_b(-8, 5'd5, 5'd3, 3'd0);
    step("beq");
    chk("beq.BranchE", 32'(BranchE), 32'h1);
    chk("beq.ImmExtE", ImmExtE, 32'hFFFFFFF8);
    chk("beq.ALUControlE", 32'(ALUControlE), 32'h1);
    chk("beq.Predict_branchE", 32'(Predict_branchE), 32'h1);

    // Stall two cycles with new D input, then flush+stall
    Predict_branchD = 0; StallE = 1; InstrD = {12'h005, 5'd5, 3'd0, 5'd9, 7'b0010011};
    step("stall1");
    step("stall2");
    chk("stall.ImmExtE", ImmExtE, 32'hFFFFFFF8);
    chk("stall.BranchE", 32'(BranchE), 32'h1);
    FlushE = 1;
    step("flush_stall");
    chk("flush.BranchE", 32'(BranchE), 32'h0);
    chk("flush.PCE", PCE, 32'h0);
    StallE = 0; FlushE = 0;

    // Write to x0 while reading x0; then read x0 again
    RegWriteW = 1; RdW = 0; ResultW = 32'hFFFF; InstrD = {7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110011};
    step("x0_wr");
    chk("x0_wr.RD1E", RD1E, 32'h0);
    RegWriteW = 0;
    step("x0_rd");
    chk("x0_rd.RD1E", RD1E, 32'h0);

    // Illegal opcode 0x7F
    InstrD = 32'hFFFFFFFF;
    step("illegal");
    chk("illegal.ctrl", {26'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE},
        32'h0);
    chk("illegal.ResultSrc_ALU", {24'd0, ResultSrcE, 2'b00, ALUControlE}, 32'h0);

    // Randomized traffic with a reset pulse in the middle
    for (int n = 0; n < 400; n++) begin
      InstrD = {$urandom()} & 32'hFFFFFF80 | 32'(ops[$urandom_range(9)]);
      if ($urandom_range(15) == 0) InstrD = 0;
      PCD = $urandom(); PCPlus4D = PCD + 4; Predict_branchD = 1'($urandom());
      RegWriteW = 1'($urandom()); RdW = 5'($urandom()); ResultW = $urandom();
      StallE = ($urandom_range(7) == 0); FlushE = ($urandom_range(7) == 0);
      step("rand");
      if (n == 200) begin
        #2 rst = 1; #1;
        exp_q = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 0;
        check_e("rst_mid");
        RegWriteW = 0; StallE = 0; FlushE = 0;
        @(negedge clk); rst = 0;
        InstrD = {7'd0, 5'd0, 5'd5, 3'd0, 5'd7, 7'b0110011};
        step("post_rst");
        chk("post_rst.RD1E_x5", RD1E, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
